// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the receive-side parity checker.
//   EVEN / ODD       : selectors for the parity scheme
//   parity_syndrome  : 1-bit syndrome of a 4-bit word plus its received parity
//                      bit; returns 1 when the word violates the chosen scheme.
// -----------------------------------------------------------------------------
package parity_pkg;

  localparam bit EVEN = 1'b0;
  localparam bit ODD  = 1'b1;

  // XOR-reduce data and parity. For the odd scheme the extra '1' inverts the
  // result, so a syndrome of 1 always means "error".
  function automatic logic parity_syndrome(input logic [3:0] data,
                                           input logic       p,
                                           input logic       odd);
    return (^data) ^ p ^ odd;
  endfunction

endpackage : parity_pkg

// File: rtl/parity_xor.sv
// -----------------------------------------------------------------------------
// parity_xor
// Purely combinational syndrome generator.
// Ports:
//   a, b, c, d : data bits 3..0 (a is the MSB)
//   p          : received parity bit
//   s          : syndrome, 1 = parity error under the selected scheme
// Parameter:
//   ODD_PARITY : EVEN (0) or ODD (1) parity scheme
// -----------------------------------------------------------------------------
module parity_xor
  import parity_pkg::*;
#(
  parameter bit ODD_PARITY = EVEN
) (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic p,
  output logic s
);

  assign s = parity_syndrome({a, b, c, d}, p, ODD_PARITY);

endmodule : parity_xor

// File: rtl/parity_checker.sv
// -----------------------------------------------------------------------------
// parity_checker
// Registered parity checker for a 4-bit word plus received parity bit, with a
// sticky error flag and a saturating error counter for status readout.
// Ports:
//   clk        : system clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   valid_in   : a/b/c/d/p sample is valid this cycle
//   a, b, c, d : data bits 3..0
//   p          : received parity bit
//   clr        : synchronous clear of err_sticky and err_count
//   e          : parity error of the last valid sample (1-cycle latency)
//   valid_out  : registered valid_in; marks that e was updated
//   err_sticky : set by any error since reset or the last clr
//   err_count  : number of errored samples, saturating at 2^CNT_W-1
// Parameters:
//   ODD_PARITY : 0 = even scheme, 1 = odd scheme
//   CNT_W      : width of the error counter
// -----------------------------------------------------------------------------
module parity_checker
  import parity_pkg::*;
#(
  parameter bit ODD_PARITY = EVEN,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             p,
  input  logic             clr,
  output logic             e,
  output logic             valid_out,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Counter increment that sticks at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             syn;
  logic             e_q,      e_d;
  logic             vld_q,    vld_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  parity_xor #(
    .ODD_PARITY (ODD_PARITY)
  ) u_parity_xor (
    .a (a),
    .b (b),
    .c (c),
    .d (d),
    .p (p),
    .s (syn)
  );

  always_comb begin
    e_d      = e_q;
    vld_d    = valid_in;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    if (valid_in) begin
      e_d = syn;
    end

    // clr wins over a same-cycle error: statistics are cleared, the error is
    // dropped from them, but e above still reports it.
    if (clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (valid_in && syn) begin
      sticky_d = 1'b1;
      cnt_d    = sat_inc(cnt_q);
    end
  end

  // ---- stage 1: registered error, valid and statistics ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q      <= 1'b0;
      vld_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      e_q      <= e_d;
      vld_q    <= vld_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign e          = e_q;
  assign valid_out  = vld_q;
  assign err_sticky = sticky_q;
  assign err_count  = cnt_q;

endmodule : parity_checker

// File: tb/tb_parity_checker.sv
// -----------------------------------------------------------------------------
// tb_parity_checker
// Three instances share one stimulus stream:
//   u0 : even scheme, 8-bit counter
//   u1 : odd scheme,  8-bit counter
//   u2 : even scheme, 2-bit counter (saturation)
// A behavioural model counts ones in the five input bits and keeps integer
// statistics clamped at each instance's limit.
// -----------------------------------------------------------------------------
module tb_parity_checker;

  logic clk, rst_n, valid_in, a, b, c, d, p, clr;
  logic e0, vo0, st0; logic [7:0] cnt0;
  logic e1, vo1, st1; logic [7:0] cnt1;
  logic e2, vo2, st2; logic [1:0] cnt2;

  int n_cmp = 0;
  int n_mis = 0;

  // model state per instance
  int m_e[3], m_vo[3], m_st[3], m_cnt[3];
  int LIM[3]  = '{255, 255, 3};
  int ODDV[3] = '{0, 1, 0};

  parity_checker #(.ODD_PARITY(1'b0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b), .c(c), .d(d),
    .p(p), .clr(clr), .e(e0), .valid_out(vo0), .err_sticky(st0), .err_count(cnt0));
  parity_checker #(.ODD_PARITY(1'b1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b), .c(c), .d(d),
    .p(p), .clr(clr), .e(e1), .valid_out(vo1), .err_sticky(st1), .err_count(cnt1));
  parity_checker #(.ODD_PARITY(1'b0), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b), .c(c), .d(d),
    .p(p), .clr(clr), .e(e2), .valid_out(vo2), .err_sticky(st2), .err_count(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_e[k] = 0; m_vo[k] = 0; m_st[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // One rising edge of the reference: error when the number of ones among
  // the five bits (plus one for the odd scheme) is odd.
  task automatic model_edge();
    int ones, s;
    ones = int'(a) + int'(b) + int'(c) + int'(d) + int'(p);
    for (int k = 0; k < 3; k++) begin
      s = (ones + ODDV[k]) % 2;
      if (valid_in) m_e[k] = s;
      m_vo[k] = valid_in ? 1 : 0;
      if (clr) begin
        m_st[k] = 0; m_cnt[k] = 0;
      end else if (valid_in && s == 1) begin
        m_st[k] = 1;
        m_cnt[k] = (m_cnt[k] + 1 > LIM[k]) ? LIM[k] : m_cnt[k] + 1;
      end
    end
  endtask

  task automatic check_all(input string w);
    chk({w, "/e0"},   32'(e0),   32'(m_e[0]));
    chk({w, "/vo0"},  32'(vo0),  32'(m_vo[0]));
    chk({w, "/st0"},  32'(st0),  32'(m_st[0]));
    chk({w, "/cnt0"}, 32'(cnt0), 32'(m_cnt[0]));
    chk({w, "/e1"},   32'(e1),   32'(m_e[1]));
    chk({w, "/vo1"},  32'(vo1),  32'(m_vo[1]));
    chk({w, "/st1"},  32'(st1),  32'(m_st[1]));
    chk({w, "/cnt1"}, 32'(cnt1), 32'(m_cnt[1]));
    chk({w, "/e2"},   32'(e2),   32'(m_e[2]));
    chk({w, "/vo2"},  32'(vo2),  32'(m_vo[2]));
    chk({w, "/st2"},  32'(st2),  32'(m_st[2]));
    chk({w, "/cnt2"}, 32'(cnt2), 32'(m_cnt[2]));
  endtask

  // Apply the current inputs across one rising edge, then compare.
  task automatic step(input string w);
    @(posedge clk);
    model_edge();
    #1;
    check_all(w);
  endtask

  task automatic drive(input logic v, input logic [3:0] abcd, input logic pp, input logic cl);
    valid_in = v; {a, b, c, d} = abcd; p = pp; clr = cl;
  endtask

  initial begin
    logic [4:0] bits;
    rst_n = 1'b0;
    model_reset();

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
      chk("rst_e0", 32'(e0), 0);
      chk("rst_vo0", 32'(vo0), 0);
      chk("rst_st0", 32'(st0), 0);
      chk("rst_cnt0", 32'(cnt0), 0);
    end
    drive(1'b0, 4'hF, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("idle");

    // exhaustive sweep, back-to-back
    for (int i = 0; i < 32; i++) begin
      bits = 5'(i);
      drive(1'b1, bits[3:0], bits[4], 1'b0);
      step("sweep");
      if (bits == 5'b11011) chk("ex_1011_p1", 32'(e0), 0);
      if (bits == 5'b01011) chk("ex_1011_p0", 32'(e0), 1);
    end
    chk("sweep_cnt0", 32'(cnt0), 16);
    chk("sweep_st0", 32'(st0), 1);
    chk("sweep_cnt1", 32'(cnt1), 16);

    // odd scheme
    drive(1'b0, 4'h0, 1'b0, 1'b1); step("clr1");
    drive(1'b1, 4'h0, 1'b1, 1'b0); step("odd_p1");
    chk("odd_0000_p1", 32'(e1), 0);
    drive(1'b1, 4'h0, 1'b0, 1'b0); step("odd_p0");
    chk("odd_0000_p0", 32'(e1), 1);

    // valid gating: erroring pattern for even scheme, not valid
    drive(1'b0, 4'h1, 1'b0, 1'b0); step("gate");
    chk("gate_vo0", 32'(vo0), 0);

    // clear priority
    drive(1'b1, 4'h1, 1'b0, 1'b1); step("clrpri");
    chk("clrpri_e0", 32'(e0), 1);
    chk("clrpri_cnt0", 32'(cnt0), 0);
    chk("clrpri_st0", 32'(st0), 0);
    drive(1'b1, 4'h1, 1'b0, 1'b0); step("clrpri2");
    chk("clrpri2_cnt0", 32'(cnt0), 1);

    // saturation on the 2-bit counter
    drive(1'b0, 4'h0, 1'b0, 1'b1); step("clr2");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'h1, 1'b0, 1'b0); step("sat");
    end
    chk("sat_cnt2", 32'(cnt2), 3);
    chk("sat_cnt0", 32'(cnt0), 5);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom),
            1'($urandom_range(0, 19) == 0));
      step("rand");
    end

    // async reset between edges
    drive(1'b1, 4'h1, 1'b0, 1'b0); step("pre_arst");
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_e0", 32'(e0), 0);
    chk("arst_st0", 32'(st0), 0);
    chk("arst_cnt0", 32'(cnt0), 0);
    check_all("arst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 4'h7, 1'b0, 1'b0);
    step("post_arst");
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    step("post_arst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_parity_checker
